// File: rtl/dp_pkg.sv
// Shared datapath types and helpers: accumulator state enum and a
// width-generic add with carry-out and optional clamp.
package dp_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    ACC,
    DUMP
  } acc_state_t;

  typedef struct packed {
    logic             carry;
    logic [MAX_W-1:0] sum;
  } add_res_t;

  localparam logic [MAX_W:0] ONE = {{MAX_W{1'b0}}, 1'b1};

  // Operands must already fit in 'width' bits (width < MAX_W).
  function automatic add_res_t sat_add(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic [6:0]       width,
    input logic             sat
  );
    logic [MAX_W:0] full;
    logic [MAX_W:0] mask;
    add_res_t       r;
    full    = {1'b0, a} + {1'b0, b};
    mask    = (ONE << width) - ONE;
    r.carry = full[width];
    if (sat && r.carry) r.sum = mask[MAX_W-1:0];
    else r.sum = full[MAX_W-1:0] & mask[MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/accum_dump_if.sv
// Sample-in / sum-out handshake bundle for accum_dump.
// slave: the accumulator side; master: producer + consumer side.
interface accum_dump_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;

  modport slave (
    input  in_data, in_valid, clear, out_ready,
    output in_ready, out_data, out_valid, ovf
  );

  modport master (
    output in_data, in_valid, clear, out_ready,
    input  in_ready, out_data, out_valid, ovf
  );
endinterface

// File: rtl/accum_add.sv
// Combinational WIDTH-bit adder with carry-out; SAT clamps the sum
// to all-ones on carry. Ports: a, b -> sum, carry.
module accum_add
  import dp_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter bit SAT   = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  add_res_t r;
  logic     unused_hi;

  always_comb begin
    r     = sat_add(MAX_W'(a), MAX_W'(b), 7'(WIDTH), SAT);
    sum   = r.sum[WIDTH-1:0];
    carry = r.carry;
  end

  assign unused_hi = ^r.sum[MAX_W-1:WIDTH];

endmodule

// File: rtl/accum_dump.sv
// Integrate-and-dump: sums LEN samples, presents the sum, restarts.
// Ports: clk, rst_n, bus (accum_dump_if.slave: in_data/in_valid/
// in_ready, clear, out_data/out_valid/out_ready, ovf).
// Macro ACCUM_DUMP_SATURATE_EN: clamp instead of wrap on overflow.
module accum_dump
  import dp_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int LEN   = 4,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  accum_dump_if.slave  bus
);

`ifdef ACCUM_DUMP_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  acc_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] sum;
  logic             carry;

  accum_add #(
    .WIDTH (WIDTH),
    .SAT   (SAT_EN)
  ) u_add (
    .a     (acc_q),
    .b     (bus.in_data),
    .sum   (sum),
    .carry (carry)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      ACC: begin
        if (bus.clear) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (bus.in_valid) begin
          ovf_d = ovf_q | carry;
          if (cnt_q == LAST) begin
            out_data_d = sum;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = DUMP;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DUMP: begin
        if (bus.out_ready) begin
          ovf_d   = 1'b0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == DUMP);
  assign bus.out_data  = out_data_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_accum_dump.sv
// Bench for accum_dump: directed cases plus random traffic
// against a sample-list reference model.
module tb_accum_dump;

  localparam int W   = 2;
  localparam int LEN = 4;
  localparam int MOD = 1 << W;
`ifdef ACCUM_DUMP_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  accum_dump_if #(.WIDTH(W)) bus ();
  accum_dump_if #(.WIDTH(W)) bus1 ();

  accum_dump #(.WIDTH(W), .LEN(LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  accum_dump #(.WIDTH(W), .LEN(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  int q[$];
  bit m_dump;
  int m_out;
  bit m_ovf;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int qsum();
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_rdy"}, bus.in_ready, !m_dump);
    chk({tag, "_vld"}, bus.out_valid, m_dump);
    chk({tag, "_ovf"}, bus.ovf, m_dump ? m_ovf : (qsum() >= MOD));
    if (m_dump) chk({tag, "_data"}, bus.out_data, m_out);
  endtask

  task automatic cyc(input int d, input bit v, input bit c,
                     input bit r, input string tag = "cyc");
    int s;
    bus.in_data   = W'(d);
    bus.in_valid  = v;
    bus.clear     = c;
    bus.out_ready = r;
    @(posedge clk);
    if (!m_dump) begin
      if (c) q.delete();
      else if (v) begin
        q.push_back(d);
        if (q.size() == LEN) begin
          s      = qsum();
          m_ovf  = (s >= MOD);
          m_out  = !m_ovf ? s : (SAT ? MOD - 1 : s % MOD);
          m_dump = 1'b1;
          q.delete();
        end
      end
    end else if (r) begin
      m_dump = 1'b0;
      m_ovf  = 1'b0;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.clear      = 1'b0;
    bus.out_ready  = 1'b0;
    bus1.in_data   = '0;
    bus1.in_valid  = 1'b0;
    bus1.clear     = 1'b0;
    bus1.out_ready = 1'b0;
    m_dump = 1'b0;
    m_out  = 0;
    m_ovf  = 1'b0;
    #12;
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_rdy", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
    cyc(0, 1, 0, 1); cyc(1, 1, 0, 1, "t1");
    chk("t1_sum", bus.out_data, 3);
    chk("t1_ovf", bus.ovf, 0);
    cyc(0, 0, 0, 1, "t1_hs");
    chk("t1_drop", bus.out_valid, 0);

    cyc(3, 1, 0, 1); cyc(3, 1, 0, 1);
    cyc(1, 1, 0, 1); cyc(0, 1, 0, 1, "t2");
    chk("t2_sum", bus.out_data, 3);
    chk("t2_ovf", bus.ovf, 1);
    cyc(0, 0, 0, 1, "t2_hs");
    chk("t2_ovfclr", bus.ovf, 0);

    cyc(2, 1, 0, 0); cyc(1, 1, 0, 0);
    cyc(3, 1, 0, 0); cyc(2, 1, 0, 0, "t4");
    for (int i = 0; i < 5; i++) begin
      cyc(3, 1, 0, 0, "t4_stall");
      chk("t4_hold", bus.out_data, SAT ? 3 : 0);
    end
    cyc(3, 0, 0, 1, "t4_hs");
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 1, "t4_next");
    chk("t4_next_sum", bus.out_data, 2);
    cyc(0, 0, 0, 1);

    cyc(2, 1, 0, 1); cyc(1, 1, 0, 1);
    cyc(3, 1, 1, 1, "t5_clr");
    cyc(1, 1, 0, 1); cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1); cyc(1, 1, 0, 1, "t5");
    chk("t5_sum", bus.out_data, 2);
    cyc(0, 0, 0, 1);

    cyc(3, 1, 0, 1); cyc(3, 1, 0, 1); cyc(1, 1, 0, 1, "t6_pre");
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ovf", bus.ovf, 0);
    chk("t6_rst_vld", bus.out_valid, 0);
    chk("t6_rst_data", bus.out_data, 0);
    q.delete();
    m_dump = 1'b0;
    m_ovf  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 1, "t6");
    chk("t6_sum", bus.out_data, SAT ? 3 : 0);
    chk("t6_ovf", bus.ovf, 1);
    cyc(0, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, MOD - 1),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 2) != 0, "rnd");
    end

    bus1.in_data  = 2'd3;
    bus1.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    chk("len1_vld", bus1.out_valid, 1);
    chk("len1_data", bus1.out_data, 3);
    chk("len1_ovf", bus1.ovf, 0);
    chk("len1_rdy", bus1.in_ready, 0);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("len1_hs", bus1.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_dump.md
Name: accum_dump

Overview:
- Integrate-and-dump accumulator; the inverse of the registered subtractor (differencer) in the datapath component library.
- Sums LEN consecutive unsigned WIDTH-bit samples accepted over a valid/ready handshake.
- Presents the block sum on a registered valid/ready output, then restarts.
- Sits downstream of differencing stages to reconstruct running totals.

Parameters:
- WIDTH, 2, sample and sum width in bits (>=2).
- LEN, 4, samples per block (>=1).
- CNT_W, $clog2(LEN+1), sample counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  sample
- in_valid  input  1  sample offered
- in_ready  output  1  block can accept a sample
- clear  input  1  synchronous abort of the current block
- out_data  output  WIDTH  block sum
- out_valid  output  1  sum available
- out_ready  input  1  consumer accepts sum
- ovf  output  1  sum of current/presented block overflowed WIDTH

Behaviour:
- Single clock clk; reset is asynchronous, active-low (rst_n).
- Reset (rst_n=0, immediate, any state): state=ACC, acc=0, cnt=0, out_data=0, out_valid=0, ovf=0, in_ready=1 after release.
- States:
  - ACC: in_ready=1, out_valid=0.
  - DUMP: in_ready=0, out_valid=1.
- Accept: in_valid && in_ready at a rising edge. acc <= acc + in_data modulo 2^WIDTH; cnt <= cnt+1. ovf sets when the carry-out is 1 and stays set (sticky) until the block is dumped.
- ACC->DUMP: on the accept that makes cnt==LEN.
  - out_data <= final sum including that sample; ovf reflects that sample; acc/cnt <= 0.
  - Latency: sum visible one cycle after the LENth accept.
- DUMP: out_data and ovf held stable while out_valid=1 && !out_ready. in_valid is ignored.
- DUMP->ACC: on out_valid && out_ready. out_valid <= 0, ovf <= 0, in_ready=1 next cycle. No same-cycle accept of a new sample (one bubble per block).
- clear:
  - In ACC: acc <= 0, cnt <= 0, ovf <= 0. A sample offered in the same cycle is discarded; clear wins.
  - In DUMP: ignored; a presented sum is never withdrawn.
- LEN=1: every accepted sample goes straight to DUMP with out_data=in_data and ovf=0.
- in_ready is combinational from state only; out_data, out_valid and ovf are registered.
- Mid-block reset discards partial sums; no partial output.

Optional Feature:
- Macro ACCUM_DUMP_SATURATE_EN.
- Defined: when an addition carries out, acc clamps to 2^WIDTH-1 and stays clamped for the rest of the block; ovf behaves as above.
- Undefined: modulo-2^WIDTH wrap, ovf flags it.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package dp_pkg holds:
  - enum acc_state_t {ACC, DUMP};
  - function sat_add(a, b, width), returning sum and carry.
- One natural sub-module: accum_add, a combinational WIDTH-bit adder with carry-out and a saturate option. It is the mirror of the subtractor and reused elsewhere.

Test Plan:
- WIDTH=2, LEN=4, SATURATE_EN off: samples 1,1,0,1, each with in_valid=1, out_ready=1.
  - After the 4th accept, next cycle out_data=3, out_valid=1, ovf=0.
  - out_valid drops the following cycle; in_ready=1.
- WIDTH=2, LEN=4, SATURATE_EN off: samples 3,3,1,0 (sum 7).
  - out_data=3 (wrap), ovf=1; ovf=0 after handshake.
- Same 3,3,1,0 with SATURATE_EN on:
  - out_data=3 (saturated), ovf=1.
- WIDTH=2, LEN=4, SATURATE_EN off: samples 2,1,3,2, out_data=0 (wrap), out_ready=0 for 5 cycles.
  - out_data=0 and out_valid stay stable; in_ready=0; extra in_valid samples are not absorbed.
  - Raising out_ready completes the handshake; the next block starts from 0.
- WIDTH=2, LEN=4: accept 2,1, then clear=1 with in_valid=1, in_data=3.
  - Sample discarded; block restarts.
  - Next samples 1,0,0,1 give out_data=2.
- WIDTH=2, LEN=4: accept 3 samples, assert rst_n=0 mid-cycle.
  - Outputs zero immediately, without waiting for clk.
  - After release, a full 4-sample block of 1s gives out_data=0, ovf=1 (wrap build).
